ram_dp_arb: RTL and testbench

- Round-robin arbiter that shares one ram_dp instance between N_REQ requesters.
- Each cycle it grants up to two requests: lane A drives the RAM's write/read port A, lane B drives write/read port B.
- Read responses are routed back to the originating requester with a fixed 1-cycle latency, whatever OUT_REG is set to on the RAM.
- Sits between client engines and the shared RAM; the only RAM driver in the system.

---
 rtl/ram_dp_arb.sv | 119 +++++++++++
 tb/tb_ram_dp_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_arb.sv
// ram_dp_arb: round-robin two-lane arbiter sharing one dual-port RAM among N_REQ requesters
module ram_dp_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int N_REQ = 4,
  parameter bit OUT_REG = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ-1:0]       req_wr_i,
  input  logic [N_REQ*AW-1:0]    req_addr_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ*BW-1:0]    req_byte_en_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [N_REQ*WIDTH-1:0] rsp_data_o,
  output logic                   ram_wr_a_en_o,
  output logic [AW-1:0]          ram_wr_a_addr_o,
  output logic [WIDTH-1:0]       ram_wr_a_data_o,
  output logic [BW-1:0]          ram_wr_a_byte_en_o,
  output logic                   ram_wr_b_en_o,
  output logic [AW-1:0]          ram_wr_b_addr_o,
  output logic [WIDTH-1:0]       ram_wr_b_data_o,
  output logic [BW-1:0]          ram_wr_b_byte_en_o,
  output logic                   ram_rd_a_en_o,
  output logic [AW-1:0]          ram_rd_a_addr_o,
  output logic                   ram_rd_b_en_o,
  output logic [AW-1:0]          ram_rd_b_addr_o,
  input  logic [WIDTH-1:0]       ram_rd_a_data_i,
  input  logic [WIDTH-1:0]       ram_rd_b_data_i
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW:0] NR = (IW+1)'(N_REQ);
  logic [IW-1:0] r_ptr, w_a_idx, w_b_idx, w_cur, w_last, r_ta_idx, r_tb_idx;
  logic [IW:0] w_sum, w_nxt;
  logic w_a_vld, w_b_vld, w_conf, w_a_wr, w_a_rd, w_b_wr, w_b_rd, r_ta_vld, r_tb_vld;
  logic [WIDTH-1:0] r_da, r_db, w_da, w_db;
  logic [N_REQ*WIDTH-1:0] r_hold;
  // scan from ptr with wrap: first valid takes lane A, next valid that is not a same-address write takes lane B
  always_comb begin
    w_a_vld = 1'b0;
    w_b_vld = 1'b0;
    w_a_idx = '0;
    w_b_idx = '0;
    w_sum = '0;
    w_cur = '0;
    w_conf = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      w_cur = IW'(w_sum >= NR ? w_sum - NR : w_sum);
      w_conf = req_wr_i[w_cur] && req_wr_i[w_a_idx] &&
               req_addr_i[w_cur*AW +: AW] == req_addr_i[w_a_idx*AW +: AW];
      if (!rst_i && req_valid_i[w_cur]) begin
        if (!w_a_vld) begin
          w_a_vld = 1'b1;
          w_a_idx = w_cur;
        end else if (!w_b_vld && !w_conf) begin
          w_b_vld = 1'b1;
          w_b_idx = w_cur;
        end
      end
    end
  end
  assign w_last = w_b_vld ? w_b_idx : w_a_idx;
  assign w_nxt = {1'b0, w_last} + 1'b1;
  // one-hot ready per requester from the two lane grants
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready_o[i] = (w_a_vld && w_a_idx == IW'(i)) || (w_b_vld && w_b_idx == IW'(i));
  end
  assign w_a_wr = w_a_vld && req_wr_i[w_a_idx];
  assign w_a_rd = w_a_vld && !req_wr_i[w_a_idx];
  assign w_b_wr = w_b_vld && req_wr_i[w_b_idx];
  assign w_b_rd = w_b_vld && !req_wr_i[w_b_idx];
  assign ram_wr_a_en_o = w_a_wr;
  assign ram_wr_a_addr_o = w_a_wr ? req_addr_i[w_a_idx*AW +: AW] : '0;
  assign ram_wr_a_data_o = w_a_wr ? req_data_i[w_a_idx*WIDTH +: WIDTH] : '0;
  assign ram_wr_a_byte_en_o = w_a_wr ? req_byte_en_i[w_a_idx*BW +: BW] : '0;
  assign ram_wr_b_en_o = w_b_wr;
  assign ram_wr_b_addr_o = w_b_wr ? req_addr_i[w_b_idx*AW +: AW] : '0;
  assign ram_wr_b_data_o = w_b_wr ? req_data_i[w_b_idx*WIDTH +: WIDTH] : '0;
  assign ram_wr_b_byte_en_o = w_b_wr ? req_byte_en_i[w_b_idx*BW +: BW] : '0;
  assign ram_rd_a_en_o = w_a_rd;
  assign ram_rd_a_addr_o = w_a_rd ? req_addr_i[w_a_idx*AW +: AW] : '0;
  assign ram_rd_b_en_o = w_b_rd;
  assign ram_rd_b_addr_o = w_b_rd ? req_addr_i[w_b_idx*AW +: AW] : '0;
  // pointer advance, read tags, local data capture (used when the RAM output is unregistered) and per-requester hold
  always_ff @(posedge clk_i) begin
    r_ptr <= rst_i ? '0 : w_a_vld ? IW'(w_nxt == NR ? (IW+1)'(0) : w_nxt) : r_ptr;
    r_ta_vld <= !rst_i && w_a_rd;
    r_tb_vld <= !rst_i && w_b_rd;
    r_ta_idx <= rst_i ? '0 : w_a_idx;
    r_tb_idx <= rst_i ? '0 : w_b_idx;
    r_da <= rst_i ? '0 : ram_rd_a_data_i;
    r_db <= rst_i ? '0 : ram_rd_b_data_i;
    r_hold <= rst_i ? '0 : rsp_data_o;
  end
  assign w_da = OUT_REG ? ram_rd_a_data_i : r_da;
  assign w_db = OUT_REG ? ram_rd_b_data_i : r_db;
  // route lane data to the tagged requester; others keep their last response; reset drops in-flight reads
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o = r_hold;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst_i && r_ta_vld && r_ta_idx == IW'(i)) begin
        rsp_valid_o[i] = 1'b1;
        rsp_data_o[i*WIDTH +: WIDTH] = w_da;
      end
      if (!rst_i && r_tb_vld && r_tb_idx == IW'(i)) begin
        rsp_valid_o[i] = 1'b1;
        rsp_data_o[i*WIDTH +: WIDTH] = w_db;
      end
    end
  end
endmodule

// File: tb/tb_ram_dp_arb.sv
// tb_ram_dp_arb: scoreboard bench driving a registered-output and a combinational-output arbiter in lockstep
module tb_ram_dp_arb;
  logic clk = 1'b0, rst;
  logic [3:0] v, wr;
  logic [2:0] ad[4];
  logic [15:0] dt[4];
  logic [1:0] be[4];
  logic [11:0] f_addr;
  logic [63:0] f_data;
  logic [7:0] f_be;
  logic [3:0] rdy0, rdy1, rv0, rv1;
  logic [63:0] rd0, rd1;
  logic wa_en0, wb_en0, ra_en0, rb_en0, wa_en1, wb_en1, ra_en1, rb_en1;
  logic [2:0] wa_addr0, wb_addr0, ra_addr0, rb_addr0, wa_addr1, wb_addr1, ra_addr1, rb_addr1;
  logic [15:0] wa_data0, wb_data0, wa_data1, wb_data1, rda0, rdb0, rda1, rdb1;
  logic [1:0] wa_be0, wb_be0, wa_be1, wb_be1;
  logic [15:0] m0[8], m1[8], sh[8];
  typedef struct {int d; int idx; logic [15:0] v; int cyc;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  logic s_wa_en, s_wb_en, s_ra_en, s_rb_en;
  logic [2:0] s_wa_addr, s_wb_addr, s_ra_addr, s_rb_addr;
  logic [15:0] s_wa_data;
  logic [7:0] s_rv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      f_addr[i*3 +: 3] = ad[i];
      f_data[i*16 +: 16] = dt[i];
      f_be[i*2 +: 2] = be[i];
    end
  end

  ram_dp_arb #(.WIDTH(16), .DEPTH(8), .N_REQ(4), .OUT_REG(1'b1)) u_reg (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy0), .req_wr_i(wr),
    .req_addr_i(f_addr), .req_data_i(f_data), .req_byte_en_i(f_be),
    .rsp_valid_o(rv0), .rsp_data_o(rd0),
    .ram_wr_a_en_o(wa_en0), .ram_wr_a_addr_o(wa_addr0), .ram_wr_a_data_o(wa_data0), .ram_wr_a_byte_en_o(wa_be0),
    .ram_wr_b_en_o(wb_en0), .ram_wr_b_addr_o(wb_addr0), .ram_wr_b_data_o(wb_data0), .ram_wr_b_byte_en_o(wb_be0),
    .ram_rd_a_en_o(ra_en0), .ram_rd_a_addr_o(ra_addr0), .ram_rd_b_en_o(rb_en0), .ram_rd_b_addr_o(rb_addr0),
    .ram_rd_a_data_i(rda0), .ram_rd_b_data_i(rdb0));

  ram_dp_arb #(.WIDTH(16), .DEPTH(8), .N_REQ(4), .OUT_REG(1'b0)) u_comb (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy1), .req_wr_i(wr),
    .req_addr_i(f_addr), .req_data_i(f_data), .req_byte_en_i(f_be),
    .rsp_valid_o(rv1), .rsp_data_o(rd1),
    .ram_wr_a_en_o(wa_en1), .ram_wr_a_addr_o(wa_addr1), .ram_wr_a_data_o(wa_data1), .ram_wr_a_byte_en_o(wa_be1),
    .ram_wr_b_en_o(wb_en1), .ram_wr_b_addr_o(wb_addr1), .ram_wr_b_data_o(wb_data1), .ram_wr_b_byte_en_o(wb_be1),
    .ram_rd_a_en_o(ra_en1), .ram_rd_a_addr_o(ra_addr1), .ram_rd_b_en_o(rb_en1), .ram_rd_b_addr_o(rb_addr1),
    .ram_rd_a_data_i(rda1), .ram_rd_b_data_i(rdb1));

  // RAM models: m0 with registered read output, m1 with combinational read
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wa_en0 && wa_be0[b]) m0[wa_addr0][8*b +: 8] <= wa_data0[8*b +: 8];
      if (wb_en0 && wb_be0[b]) m0[wb_addr0][8*b +: 8] <= wb_data0[8*b +: 8];
      if (wa_en1 && wa_be1[b]) m1[wa_addr1][8*b +: 8] <= wa_data1[8*b +: 8];
      if (wb_en1 && wb_be1[b]) m1[wb_addr1][8*b +: 8] <= wb_data1[8*b +: 8];
    end
    if (ra_en0) rda0 <= m0[ra_addr0];
    if (rb_en0) rdb0 <= m0[rb_addr0];
  end
  assign rda1 = m1[ra_addr1];
  assign rdb1 = m1[rb_addr1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic [3:0] rv, input logic [63:0] rd);
    for (int i = 0; i < 4; i++) begin
      if (rv[i]) begin
        int f = -1;
        for (int k = 0; k < q.size(); k++)
          if (f < 0 && q[k].d == d && q[k].idx == i) f = k;
        if (f < 0) chk($sformatf("rsp_unexp d%0d r%0d", d, i), 64'(rv[i]), 64'd0);
        else begin
          chk($sformatf("rsp_data d%0d r%0d", d, i), 64'(rd[i*16 +: 16]), 64'(q[f].v));
          chk($sformatf("rsp_cyc d%0d r%0d", d, i), 64'(cyc), 64'(q[f].cyc));
          q.delete(f);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv0, rd0);
    mon(1, rv1, rd1);
  end

  task automatic req(input int i, input logic w, input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    v[i] = 1'b1;
    wr[i] = w;
    ad[i] = a;
    dt[i] = d;
    be[i] = b;
  endtask

  task automatic step(input logic [3:0] exp, input bit push = 1'b1);
    exp_t e;
    @(negedge clk);
    chk("rdy_reg", 64'(rdy0), 64'(exp));
    chk("rdy_comb", 64'(rdy1), 64'(exp));
    {s_wa_en, s_wa_addr, s_wa_data, s_wb_en, s_wb_addr} = {wa_en0, wa_addr0, wa_data0, wb_en0, wb_addr0};
    {s_ra_en, s_ra_addr, s_rb_en, s_rb_addr, s_rv} = {ra_en0, ra_addr0, rb_en0, rb_addr0, rv1, rv0};
    for (int i = 0; i < 4; i++)
      if (push && exp[i] && !wr[i])
        for (int d = 0; d < 2; d++) begin
          e.d = d;
          e.idx = i;
          e.v = sh[ad[i]];
          e.cyc = cyc + 1;
          q.push_back(e);
        end
    for (int i = 0; i < 4; i++)
      if (exp[i] && wr[i])
        for (int b = 0; b < 2; b++)
          if (be[i][b]) sh[ad[i]][8*b +: 8] = dt[i][8*b +: 8];
    @(posedge clk);
    #1;
    v = v & ~exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v = '0;
    wr = '0;
    for (int i = 0; i < 8; i++) sh[i] = '0;
    for (int i = 0; i < 4; i++) req(i, 1'b0, 3'(i), 16'h0, 2'b00);
    repeat (2) @(negedge clk);
    chk("rst_rdy_reg", 64'(rdy0), 64'd0);
    chk("rst_rdy_comb", 64'(rdy1), 64'd0);
    chk("rst_rv", 64'({rv1, rv0}), 64'd0);
    chk("rst_rd_reg", rd0, 64'd0);
    chk("rst_rd_comb", rd1, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '0;
    for (int i = 0; i < 4; i++) req(i, 1'b1, 3'(i), 16'(16'h10 + i), 2'b11);
    step(4'b0011);
    step(4'b1100);
    for (int i = 0; i < 4; i++) req(i, 1'b0, 3'(i), 16'h0, 2'b00);
    step(4'b0011);
    chk("rd_lanes", 64'({s_ra_en, s_ra_addr, s_rb_en, s_rb_addr}), 64'({1'b1, 3'd0, 1'b1, 3'd1}));
    step(4'b1100);
    for (int i = 1; i < 4; i++) req(i, 1'b0, 3'(i), 16'h0, 2'b00);
    step(4'b0110);
    step(4'b1000);
    req(0, 1'b1, 3'd3, 16'h00A5, 2'b11);
    step(4'b0001);
    chk("wr_a", 64'({s_wa_en, s_wa_addr, s_wa_data, s_wb_en}), 64'({1'b1, 3'd3, 16'h00A5, 1'b0}));
    req(0, 1'b0, 3'd3, 16'h0, 2'b00);
    step(4'b0001);
    chk("rd_a", 64'({s_ra_en, s_ra_addr, s_wa_en}), 64'({1'b1, 3'd3, 1'b0}));
    req(1, 1'b1, 3'd5, 16'h0011, 2'b11);
    req(2, 1'b1, 3'd5, 16'h0022, 2'b11);
    req(3, 1'b1, 3'd6, 16'h0033, 2'b11);
    step(4'b1010);
    chk("ww_skip", 64'({s_wa_addr, s_wa_data, s_wb_en, s_wb_addr}), 64'({3'd5, 16'h0011, 1'b1, 3'd6}));
    step(4'b0100);
    req(3, 1'b0, 3'd5, 16'h0, 2'b00);
    req(0, 1'b0, 3'd6, 16'h0, 2'b00);
    step(4'b1001);
    req(1, 1'b1, 3'd2, 16'hBEEF, 2'b11);
    step(4'b0010);
    req(0, 1'b1, 3'd2, 16'h1234, 2'b11);
    req(1, 1'b0, 3'd2, 16'h0, 2'b00);
    step(4'b0011);
    chk("rw_lanes", 64'({s_wa_en, s_wa_addr, s_rb_en, s_rb_addr}), 64'({1'b1, 3'd2, 1'b1, 3'd2}));
    req(0, 1'b1, 3'd2, 16'h55AA, 2'b01);
    step(4'b0001);
    req(1, 1'b0, 3'd2, 16'h0, 2'b00);
    step(4'b0010);
    req(0, 1'b0, 3'd3, 16'h0, 2'b00);
    step(4'b0001, 1'b0);
    rst = 1'b1;
    req(0, 1'b0, 3'd0, 16'h0, 2'b00);
    req(2, 1'b0, 3'd2, 16'h0, 2'b00);
    req(3, 1'b0, 3'd1, 16'h0, 2'b00);
    @(negedge clk);
    chk("midrst_rv", 64'({rv1, rv0}), 64'd0);
    chk("midrst_rdy", 64'({rdy1, rdy0}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0101);
    chk("postrst_rv", 64'(s_rv), 64'd0);
    step(4'b1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_reg", 64'(rd0[63:48]), 64'h11);
    chk("hold_comb", 64'(rd1[63:48]), 64'h11);
    chk("pending", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
